maxpool_unit: RTL and testbench
===============================

MAXPOOL_UNIT -- requirements
Module: maxpool_unit

Interface
REQ-001 Parameter DATA_W, default 8, pixel width (signed two's complement).
REQ-002 Parameter MAX_SIZE, default 32, largest supported feature-map edge.
REQ-003 clk  input  1  sole clock, all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 pool_en  input  1  level enable from the layer sequencer, high for the whole pooling state.
REQ-006 size_in  input  8  feature-map edge length, sampled at job start.
REQ-007 channels_in  input  8  channel count, sampled at job start.
REQ-008 in_valid, in_data  input  1, DATA_W  upstream pixel stream: channel-major, then row-major.
REQ-009 in_ready  output  1  pixel accepted when in_valid && in_ready.
REQ-010 out_valid, out_data  output  1, DATA_W  pooled pixel stream, same ordering.
REQ-011 out_ready  input  1  downstream accept; transfer when out_valid && out_ready.
REQ-012 pool_done  output  1  single-cycle pulse at job completion; drives the sequencer's pooling-done input.

Function
REQ-013 States: IDLE, RUN, DRAIN, DONE, HOLD.
REQ-014 IDLE -> RUN when pool_en=1; latch size_in and channels_in; clear col/row/ch counters.
REQ-015 IDLE -> DONE directly when pool_en=1 and (size_in<2 or channels_in=0); no pixels accepted.
REQ-016 in_ready = (state==RUN) && (!out_valid || out_ready).
REQ-017 Window 2x2, stride 2, signed max over the four pixels.
REQ-018 Even row, odd col: store max(prev pixel, current) into row buffer entry col/2.
REQ-019 Odd row, odd col: out_data <= max(buffer[col/2], max(prev pixel, current)); out_valid <= 1 on the following edge (latency 1 cycle after the window's bottom-right pixel).
REQ-020 Odd size: last column and last row pixels are accepted and counted but produce no output (floor behaviour).
REQ-021 Counters: col wraps at size-1 and increments row; row wraps at size-1 and increments ch.
REQ-022 After the last pixel of the last channel is accepted: RUN -> DRAIN.
REQ-023 DRAIN -> DONE once out_valid=0 or the output transfer completes in that cycle.
REQ-024 DONE: pool_done=1 for exactly one cycle, then -> HOLD.
REQ-025 HOLD -> IDLE when pool_en=0; prevents a second job while the sequencer is still in the pooling state.
REQ-026 pool_en falling in RUN or DRAIN aborts: -> IDLE next edge, out_valid cleared, no pool_done.
REQ-027 out_data and out_valid hold stable while out_valid && !out_ready.
REQ-028 Output produced and accepted in the same cycle as its successor is generated: no bubble, no loss.

Reset
REQ-029 rst forces state IDLE; counters 0; out_valid=0, out_data=0, in_ready=0, pool_done=0.
REQ-030 rst mid-job discards the job; row buffer contents need not be cleared.
REQ-031 rst has priority over every other condition.

Structure
REQ-032 DATA_W, MAX_SIZE and the state encodings are defined in the shared accelerator package/header.
REQ-033 Row buffer is one sub-module, pool_row_buf: MAX_SIZE/2 entries x DATA_W, one write port, one async read port.
REQ-034 Counter widths are derived from MAX_SIZE (clog2(MAX_SIZE)) and from 8 bits for ch.

Verification
REQ-035 4x4, 1 channel, pixels 0..15 row-major, out_ready=1 -> outputs 5,7,13,15, then one pool_done pulse.
REQ-036 2x2, 3 channels, pixels {-5,-3,-8,-4},{1,2,3,4},{-128,127,0,0} -> outputs -3,4,127; pool_done once.
REQ-037 4x4 with out_ready=0 for 10 cycles after the first output -> out_data holds 5, in_ready=0, no data lost; sequence still 5,7,13,15.
REQ-038 5x5, 1 channel -> 25 inputs accepted, exactly 4 outputs, then pool_done.
REQ-039 pool_en dropped after 6 pixels of a 4x4 job -> IDLE, out_valid=0, no pool_done; the next job runs cleanly.
REQ-040 size_in=0 with pool_en=1 -> pool_done within 2 cycles, in_ready never 1; HOLD until pool_en=0.

Source files
------------

// File: rtl/maxpool_unit_pkg.sv
// maxpool_unit_pkg: shared pixel width, max feature-map edge and FSM state encoding for the max-pool unit
package maxpool_unit_pkg;
  localparam int DATA_W = 8;
  localparam int MAX_SIZE = 32;
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, HOLD} pool_state_t;
endpackage

// File: rtl/pool_row_buf.sv
// pool_row_buf: row buffer of horizontal pair maxima; ports clk, we/waddr/wdata write, raddr/rdata async read
module pool_row_buf #(
  parameter int DATA_W = maxpool_unit_pkg::DATA_W,
  parameter int DEPTH = maxpool_unit_pkg::MAX_SIZE / 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/maxpool_unit.sv
// maxpool_unit: 2x2/stride-2 signed max pool; ports clk/rst, pool_en/size_in/channels_in job, in_* stream, out_* stream, pool_done pulse
module maxpool_unit #(
  parameter int DATA_W = maxpool_unit_pkg::DATA_W,
  parameter int MAX_SIZE = maxpool_unit_pkg::MAX_SIZE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pool_en,
  input  logic [7:0]               size_in,
  input  logic [7:0]               channels_in,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  input  logic                     out_ready,
  output logic                     pool_done
);
  import maxpool_unit_pkg::*;
  localparam int CW = $clog2(MAX_SIZE);
  pool_state_t state, state_nx;
  logic [7:0] size_r, chans_r, ch;
  logic [CW-1:0] col, row;
  logic signed [DATA_W-1:0] prev, buf_rd, pair_max, win_max;
  logic accept, col_last, row_last, ch_last, trivial, abort;
  assign in_ready = state == RUN && (!out_valid || out_ready);
  assign accept = in_valid && in_ready;
  assign col_last = {{(8-CW){1'b0}}, col} == size_r - 8'd1;
  assign row_last = {{(8-CW){1'b0}}, row} == size_r - 8'd1;
  assign ch_last = ch == chans_r - 8'd1;
  assign trivial = size_in < 8'd2 || channels_in == 8'd0;
  assign abort = (state == RUN || state == DRAIN) && !pool_en;
  assign pair_max = prev > in_data ? prev : in_data;
  assign win_max = buf_rd > pair_max ? buf_rd : pair_max;
  assign pool_done = state == DONE;
  pool_row_buf #(.DATA_W(DATA_W), .DEPTH(MAX_SIZE / 2)) u_row_buf (
    .clk  (clk),
    .we   (accept && !row[0] && col[0]),
    .waddr(col[CW-1:1]),
    .wdata(pair_max),
    .raddr(col[CW-1:1]),
    .rdata(buf_rd)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = !pool_en ? IDLE : trivial ? DONE : RUN;
      RUN:     state_nx = !pool_en ? IDLE : (accept && col_last && row_last && ch_last) ? DRAIN : RUN;
      DRAIN:   state_nx = !pool_en ? IDLE : (!out_valid || out_ready) ? DONE : DRAIN;
      DONE:    state_nx = HOLD;
      HOLD:    state_nx = pool_en ? HOLD : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      col <= '0;
      row <= '0;
      ch <= '0;
      size_r <= '0;
      chans_r <= '0;
      prev <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && pool_en) begin
        size_r <= size_in;
        chans_r <= channels_in;
        col <= '0;
        row <= '0;
        ch <= '0;
      end
      if (accept) begin
        col <= col_last ? '0 : col + 1'b1;
        if (col_last) row <= row_last ? '0 : row + 1'b1;
        if (col_last && row_last) ch <= ch + 8'd1;
        if (!col[0]) prev <= in_data;
      end
      if (abort) out_valid <= 1'b0;
      else if (accept && row[0] && col[0]) begin
        out_valid <= 1'b1;
        out_data <= win_max;
      end else if (out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_maxpool_unit.sv
// tb_maxpool_unit: randomized self-checking bench for maxpool_unit against a behavioural pooling model
module tb_maxpool_unit;
  localparam int DW = 8;
  logic clk = 1'b0;
  logic rst, pool_en, in_valid, in_ready, out_valid, out_ready, pool_done;
  logic [7:0] size_in, channels_in;
  logic signed [DW-1:0] in_data, out_data;
  int checks = 0;
  int errors = 0;
  int px[$];
  always #5 clk = ~clk;
  maxpool_unit dut (
    .clk        (clk),
    .rst        (rst),
    .pool_en    (pool_en),
    .size_in    (size_in),
    .channels_in(channels_in),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .pool_done  (pool_done)
  );
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic ramp(input int n);
    px.delete();
    for (int i = 0; i < n; i++) px.push_back(i);
  endtask
  task automatic rand_px(input int n);
    px.delete();
    for (int i = 0; i < n; i++) px.push_back(int'($urandom_range(255)) - 128);
  endtask
  task automatic run_job(input int sz, input int nch, input int vp, input int rp, input int abort_at, input bit stall);
    int n, idx, dn, cyc, first_done, stall_left, pv_data, m;
    bit pv_stall;
    int exq[$];
    n = (sz >= 2 && nch > 0) ? sz * sz * nch : 0;
    if (n > 0)
      for (int c = 0; c < nch; c++)
        for (int r = 0; r + 1 < sz; r += 2)
          for (int k = 0; k + 1 < sz; k += 2) begin
            m = px[c*sz*sz + r*sz + k];
            if (px[c*sz*sz + r*sz + k + 1] > m) m = px[c*sz*sz + r*sz + k + 1];
            if (px[c*sz*sz + (r+1)*sz + k] > m) m = px[c*sz*sz + (r+1)*sz + k];
            if (px[c*sz*sz + (r+1)*sz + k + 1] > m) m = px[c*sz*sz + (r+1)*sz + k + 1];
            exq.push_back(m);
          end
    pool_en = 1'b1;
    size_in = 8'(sz);
    channels_in = 8'(nch);
    idx = 0; dn = 0; cyc = 0; first_done = -1; stall_left = -1; pv_stall = 1'b0; pv_data = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (abort_at >= 0 && idx == abort_at) begin
        pool_en = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 0);
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          if (pool_done) dn++;
        end
        chk("abort_no_done", dn, 0);
        return;
      end
      in_valid = idx < n && $urandom_range(99) < vp;
      in_data = idx < n ? px[idx][DW-1:0] : '0;
      out_ready = (stall && stall_left != 0) ? 1'b0 : $urandom_range(99) < rp;
      #1;
      if (pv_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, pv_data);
      end
      if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
      if (idx >= n) chk("in_ready_after_last", in_ready, 0);
      if (pool_done) begin
        dn++;
        if (first_done < 0) first_done = cyc;
      end
      if (out_valid && out_ready) begin
        chk("out_expected", int'(exq.size() > 0), 1);
        if (exq.size() > 0) chk("out_data", out_data, exq.pop_front());
      end
      if (stall && stall_left < 0 && out_valid) stall_left = 10;
      else if (stall_left > 0) stall_left--;
      pv_stall = out_valid && !out_ready;
      pv_data = out_data;
      if (in_valid && in_ready) idx++;
      if (dn > 0 && cyc - first_done >= 3) break;
      if (cyc > 4000) break;
    end
    chk("done_pulses", dn, 1);
    chk("inputs_accepted", idx, n);
    chk("outputs_left", exq.size(), 0);
    if (n == 0) chk("trivial_done_latency", int'(first_done <= 2), 1);
    pool_en = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_done", pool_done, 0);
    chk("post_valid", out_valid, 0);
  endtask
  initial begin
    rst = 1'b1; pool_en = 1'b0; size_in = '0; channels_in = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_pool_done", pool_done, 0);
    rst = 1'b0;
    @(negedge clk);
    ramp(16);
    run_job(4, 1, 100, 100, -1, 1'b0);
    px = '{-5, -3, -8, -4, 1, 2, 3, 4, -128, 127, 0, 0};
    run_job(2, 3, 100, 100, -1, 1'b0);
    ramp(16);
    run_job(4, 1, 100, 100, -1, 1'b1);
    rand_px(25);
    run_job(5, 1, 80, 80, -1, 1'b0);
    ramp(16);
    run_job(4, 1, 100, 100, 6, 1'b0);
    ramp(16);
    run_job(4, 1, 100, 100, -1, 1'b0);
    run_job(0, 1, 100, 100, -1, 1'b0);
    run_job(6, 0, 100, 100, -1, 1'b0);
    pool_en = 1'b1; size_in = 8'd4; channels_in = 8'd1; in_valid = 1'b1; in_data = 8'sd9; out_ready = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    rst = 1'b0; pool_en = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 10; j++) begin
      int sz, nch;
      sz = $urandom_range(9, 1);
      nch = $urandom_range(3, 1);
      rand_px(sz * sz * nch);
      run_job(sz, nch, $urandom_range(100, 30), $urandom_range(100, 30), -1, 1'b0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
